mr_cmd_scheduler: RTL

Schedules per-rank mode-register write (MRW) and mode-register read (MRR) requests from apb_slave_port onto one shared mode-register command channel toward the DRAM PHY.
- Arbitrates round-robin across NB_RANK ranks and enforces a minimum command gap (TMRD).
- Returns one-cycle done pulses that drive mrw_done_status_i / mrr_done_status_i of the APB slave.
- Captures MRR read data for software.

---
 rtl/mr_cmd_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mr_cmd_scheduler.sv
// Round-robin scheduler of per-rank MRW/MRR requests onto one MR command channel.
// Optional MRR response timeout with error flag when MR_TIMEOUT_EN is defined.
module mr_cmd_scheduler #(
  parameter int NB_RANK   = 8,
  parameter int MRA_WIDTH = 8,
  parameter int MRD_WIDTH = 8,
  parameter int TMRD      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_RANK-1:0]             rank_mrw_i,
  input  logic [NB_RANK-1:0]             rank_mrr_i,
  input  logic [NB_RANK*MRA_WIDTH-1:0]   mraddr_i,
  input  logic [NB_RANK*MRD_WIDTH-1:0]   mrdata_i,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output logic                           cmd_write_o,
  output logic [$clog2(NB_RANK)-1:0]     cmd_rank_o,
  output logic [MRA_WIDTH-1:0]           cmd_addr_o,
  output logic [MRD_WIDTH-1:0]           cmd_wdata_o,
  input  logic                           rsp_valid_i,
  input  logic [MRD_WIDTH-1:0]           rsp_rdata_i,
  output logic [NB_RANK-1:0]             mrw_done_o,
  output logic [NB_RANK-1:0]             mrr_done_o,
  output logic [MRD_WIDTH-1:0]           mrr_rdata_o,
`ifdef MR_TIMEOUT_EN
  output logic                           mrr_err_o,
`endif
  output logic                           busy_o
);

  localparam int RW = $clog2(NB_RANK);
  localparam int GW = $clog2(TMRD + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, DONE, GAP} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rr_ptr, gnt_rank, idx;
  logic                  gnt_found;
  logic [NB_RANK-1:0]    mask_w, mask_r, req_w, req_r, done_oh;
  logic                  cmd_write_q;
  logic [RW-1:0]         cmd_rank_q;
  logic [MRA_WIDTH-1:0]  cmd_addr_q;
  logic [MRD_WIDTH-1:0]  cmd_wdata_q;
  logic [GW-1:0]         gap_cnt;
`ifdef MR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]         tmo_cnt;
  logic                  err_q;
`endif

  // Masks block a level request that is still held after its done pulse.
  assign req_w   = rank_mrw_i & ~mask_w;
  assign req_r   = rank_mrr_i & ~mask_r;
  assign done_oh = {{(NB_RANK-1){1'b0}}, 1'b1} << cmd_rank_q;

  always_comb begin
    gnt_found = 1'b0;
    gnt_rank  = '0;
    idx       = '0;
    for (int i = 0; i < NB_RANK; i++) begin
      idx = rr_ptr + i[RW-1:0];
      if (!gnt_found && (req_w[idx] | req_r[idx])) begin
        gnt_found = 1'b1;
        gnt_rank  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_found) state_d = ISSUE;
      ISSUE:    if (cmd_ready_i) state_d = cmd_write_q ? DONE : WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_valid_i) state_d = DONE;
`ifdef MR_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT - 1)) state_d = DONE;
`endif
      end
      DONE:     state_d = GAP;
      GAP:      if (gap_cnt <= GW'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_o = (state_q == ISSUE);
    busy_o      = (state_q != IDLE);
    mrw_done_o  = (state_q == DONE &&  cmd_write_q) ? done_oh : '0;
    mrr_done_o  = (state_q == DONE && !cmd_write_q) ? done_oh : '0;
`ifdef MR_TIMEOUT_EN
    mrr_err_o   = (state_q == DONE) && err_q;
`endif
  end

  assign cmd_write_o = cmd_write_q;
  assign cmd_rank_o  = cmd_rank_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_wdata_o = cmd_wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      mask_w      <= '0;
      mask_r      <= '0;
      cmd_write_q <= 1'b0;
      cmd_rank_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gap_cnt     <= '0;
      mrr_rdata_o <= '0;
`ifdef MR_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      mask_w <= (mask_w | mrw_done_o) & rank_mrw_i;
      mask_r <= (mask_r | mrr_done_o) & rank_mrr_i;
      case (state_q)
        IDLE: if (gnt_found) begin
          cmd_rank_q  <= gnt_rank;
          cmd_write_q <= req_w[gnt_rank];
          cmd_addr_q  <= mraddr_i[int'(gnt_rank)*MRA_WIDTH +: MRA_WIDTH];
          cmd_wdata_q <= req_w[gnt_rank] ? mrdata_i[int'(gnt_rank)*MRD_WIDTH +: MRD_WIDTH] : '0;
          rr_ptr      <= gnt_rank + 1'b1;
        end
`ifdef MR_TIMEOUT_EN
        ISSUE: tmo_cnt <= '0;
`endif
        WAIT_RSP: begin
          if (rsp_valid_i) mrr_rdata_o <= rsp_rdata_i;
`ifdef MR_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            mrr_rdata_o <= '1;
            err_q       <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        DONE: begin
          gap_cnt <= GW'(TMRD);
`ifdef MR_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        GAP: gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
